// File: rtl/riscv_mem_port_arbiter_if.sv
// Bundle of every signal between the core-facing request/response streams
// and the single-port memory model.
//   slave  : the arbiter's view (request inputs, response outputs)
//   master : the environment's view (core + memory model)
// Request msg layout  : {type, addr[p_addr_sz], len[2], data[p_data_sz]}
// Response msg layout : {type, len[2], data[p_data_sz]}
interface riscv_mem_port_arbiter_if #(
  parameter int p_addr_sz         = 32,
  parameter int p_data_sz         = 32,
  parameter int p_max_outstanding = 4
);
  localparam int REQ_W  = 1 + p_addr_sz + 2 + p_data_sz;
  localparam int RESP_W = 1 + 2 + p_data_sz;
  localparam int CNT_W  = $clog2(p_max_outstanding) + 1;

  logic [REQ_W-1:0]  imemreq0_msg, imemreq1_msg, dmemreq_msg, memreq_msg;
  logic              imemreq0_val, imemreq1_val, dmemreq_val, memreq_val;
  logic              imemreq0_rdy, imemreq1_rdy, dmemreq_rdy, memreq_rdy;
  logic [RESP_W-1:0] imemresp0_msg, imemresp1_msg, dmemresp_msg, memresp_msg;
  logic              imemresp0_val, imemresp1_val, dmemresp_val, memresp_val;
  logic              imemresp0_rdy, imemresp1_rdy, dmemresp_rdy, memresp_rdy;
  logic              err_spurious;
  logic [CNT_W-1:0]  outstanding;

  modport slave (
    input  imemreq0_msg, imemreq0_val, imemreq1_msg, imemreq1_val,
           dmemreq_msg, dmemreq_val, memreq_rdy,
           imemresp0_rdy, imemresp1_rdy, dmemresp_rdy, memresp_msg, memresp_val,
    output imemreq0_rdy, imemreq1_rdy, dmemreq_rdy, memreq_msg, memreq_val,
           imemresp0_msg, imemresp0_val, imemresp1_msg, imemresp1_val,
           dmemresp_msg, dmemresp_val, memresp_rdy, err_spurious, outstanding
  );

  modport master (
    output imemreq0_msg, imemreq0_val, imemreq1_msg, imemreq1_val,
           dmemreq_msg, dmemreq_val, memreq_rdy,
           imemresp0_rdy, imemresp1_rdy, dmemresp_rdy, memresp_msg, memresp_val,
    input  imemreq0_rdy, imemreq1_rdy, dmemreq_rdy, memreq_msg, memreq_val,
           imemresp0_msg, imemresp0_val, imemresp1_msg, imemresp1_val,
           dmemresp_msg, dmemresp_val, memresp_rdy, err_spurious, outstanding
  );
endinterface

// File: rtl/riscv_mem_port_arbiter.sv
// Merges imem0 / imem1 / dmem request streams onto one single-port memory.
// Round-robin request arbitration; in-order responses are steered back to
// the requesting port using a FIFO of in-flight port tags.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-low
//   io_bus : riscv_mem_port_arbiter_if.slave (request/response streams,
//            memory side, err_spurious sticky flag, outstanding count)
//
// Priority pointer FSM:
//   state | meaning
//   PRI_0 | scan order imem0, imem1, dmem
//   PRI_1 | scan order imem1, dmem, imem0
//   PRI_2 | scan order dmem, imem0, imem1
module riscv_mem_port_arbiter #(
  parameter int p_addr_sz         = 32,
  parameter int p_data_sz         = 32,
  parameter int p_max_outstanding = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  riscv_mem_port_arbiter_if.slave       io_bus
);
  localparam int REQ_W = 1 + p_addr_sz + 2 + p_data_sz;
  localparam int PTR_W = $clog2(p_max_outstanding);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {PRI_0 = 2'd0, PRI_1 = 2'd1, PRI_2 = 2'd2} pri_e;

  pri_e             r_pri, w_pri_nxt;
  logic [1:0]       r_tags [p_max_outstanding];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [2:0]       w_req_val;
  logic [1:0]       w_winner, w_head;
  logic             w_any, w_full, w_empty, w_gnt_rdy;
  logic             w_req_fire, w_resp_fire, w_push, w_pop;
  logic [REQ_W-1:0] w_req_msg;

  assign w_req_val = {io_bus.dmemreq_val, io_bus.imemreq1_val, io_bus.imemreq0_val};
  assign w_any     = |w_req_val;
  assign w_full    = (r_count == CNT_W'(p_max_outstanding));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_tags[r_rd_ptr];

  // Winner selection and pointer advance; pointer moves past the winner
  // only when the request actually fires.
  always_comb begin
    w_winner  = 2'd0;
    w_pri_nxt = r_pri;
    case (r_pri)
      PRI_0:   w_winner = w_req_val[0] ? 2'd0 : (w_req_val[1] ? 2'd1 : (w_req_val[2] ? 2'd2 : 2'd0));
      PRI_1:   w_winner = w_req_val[1] ? 2'd1 : (w_req_val[2] ? 2'd2 : (w_req_val[0] ? 2'd0 : 2'd1));
      PRI_2:   w_winner = w_req_val[2] ? 2'd2 : (w_req_val[0] ? 2'd0 : (w_req_val[1] ? 2'd1 : 2'd2));
      default: w_winner = 2'd0;
    endcase
    if (w_req_fire) begin
      case (w_winner)
        2'd0:    w_pri_nxt = PRI_1;
        2'd1:    w_pri_nxt = PRI_2;
        default: w_pri_nxt = PRI_0;
      endcase
    end
  end

  always_comb begin
    case (w_winner)
      2'd0:    w_req_msg = io_bus.imemreq0_msg;
      2'd1:    w_req_msg = io_bus.imemreq1_msg;
      default: w_req_msg = io_bus.dmemreq_msg;
    endcase
  end

  // Full is judged on registered occupancy, so a same-cycle pop never
  // opens a slot for a push.
  assign w_gnt_rdy           = w_any && io_bus.memreq_rdy && !w_full;
  assign io_bus.memreq_val   = w_any && !w_full;
  assign io_bus.memreq_msg   = w_req_msg;
  assign io_bus.imemreq0_rdy = w_gnt_rdy && (w_winner == 2'd0);
  assign io_bus.imemreq1_rdy = w_gnt_rdy && (w_winner == 2'd1);
  assign io_bus.dmemreq_rdy  = w_gnt_rdy && (w_winner == 2'd2);

  assign io_bus.imemresp0_val = io_bus.memresp_val && !w_empty && (w_head == 2'd0);
  assign io_bus.imemresp1_val = io_bus.memresp_val && !w_empty && (w_head == 2'd1);
  assign io_bus.dmemresp_val  = io_bus.memresp_val && !w_empty && (w_head == 2'd2);
  assign io_bus.imemresp0_msg = io_bus.memresp_msg;
  assign io_bus.imemresp1_msg = io_bus.memresp_msg;
  assign io_bus.dmemresp_msg  = io_bus.memresp_msg;

  // An empty FIFO always accepts so a stray response cannot wedge memory.
  always_comb begin
    if (w_empty) begin
      io_bus.memresp_rdy = 1'b1;
    end else begin
      case (w_head)
        2'd0:    io_bus.memresp_rdy = io_bus.imemresp0_rdy;
        2'd1:    io_bus.memresp_rdy = io_bus.imemresp1_rdy;
        2'd2:    io_bus.memresp_rdy = io_bus.dmemresp_rdy;
        default: io_bus.memresp_rdy = 1'b0;
      endcase
    end
  end

  assign w_req_fire  = io_bus.memreq_val && io_bus.memreq_rdy;
  assign w_resp_fire = io_bus.memresp_val && io_bus.memresp_rdy;
  assign w_push      = w_req_fire;
  assign w_pop       = w_resp_fire && !w_empty;

  assign io_bus.err_spurious = r_err;
  assign io_bus.outstanding  = r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pri    <= PRI_0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_pri <= w_pri_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_resp_fire && w_empty) r_err <= 1'b1;
    end
  end

  // Tag storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (reset && w_push) r_tags[r_wr_ptr] <= w_winner;
  end
endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Scoreboard bench for riscv_mem_port_arbiter: directed requests push their
// expected grant and response into queues; a monitor pops and compares on
// every memory-request fire and every delivered port response.
module tb_riscv_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MO = 4;
  localparam int REQ_W = 1 + AW + 2 + DW;
  localparam int RESP_W = 1 + 2 + DW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  riscv_mem_port_arbiter_if #(.p_addr_sz(AW), .p_data_sz(DW), .p_max_outstanding(MO)) bus ();

  riscv_mem_port_arbiter #(.p_addr_sz(AW), .p_data_sz(DW), .p_max_outstanding(MO)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  logic [REQ_W-1:0]  req_q [3][$];
  logic [RESP_W-1:0] exp_q [3][$];
  int                exp_gnt[$];
  logic [RESP_W-1:0] mem_q[$];
  logic [31:0]       mem [logic [31:0]];
  logic              mem_stall = 1'b0;
  logic              inj_spur = 1'b0;
  logic [2:0]        resp_rdy = 3'b111;
  logic [2:0]        req_fire_pend = 3'b000;
  logic              mresp_fire_pend = 1'b0;
  int                checks = 0;
  int                errors = 0;

  wire [2:0] w_req_val  = {bus.dmemreq_val, bus.imemreq1_val, bus.imemreq0_val};
  wire [2:0] w_req_rdy  = {bus.dmemreq_rdy, bus.imemreq1_rdy, bus.imemreq0_rdy};
  wire [2:0] w_resp_val = {bus.dmemresp_val, bus.imemresp1_val, bus.imemresp0_val};

  function automatic logic [RESP_W-1:0] port_resp_msg(input int p);
    case (p)
      0:       return bus.imemresp0_msg;
      1:       return bus.imemresp1_msg;
      default: return bus.dmemresp_msg;
    endcase
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hD00D, a[15:0]};
  endfunction

  task automatic set_req(input int p, input logic v, input logic [REQ_W-1:0] m);
    case (p)
      0:       begin bus.imemreq0_val = v; bus.imemreq0_msg = m; end
      1:       begin bus.imemreq1_val = v; bus.imemreq1_msg = m; end
      default: begin bus.dmemreq_val  = v; bus.dmemreq_msg  = m; end
    endcase
  endtask

  // Driver + memory model: all DUT inputs change at the falling edge.
  initial begin
    logic [REQ_W-1:0] m;
    logic             from_q;
    for (int p = 0; p < 3; p++) set_req(p, 1'b0, '0);
    bus.memreq_rdy  = 1'b1;
    bus.memresp_val = 1'b0;
    bus.memresp_msg = '0;
    bus.imemresp0_rdy = 1'b1;
    bus.imemresp1_rdy = 1'b1;
    bus.dmemresp_rdy  = 1'b1;
    mem[32'h000] = 32'h1111_0000;
    mem[32'h004] = 32'h1111_0004;
    mem[32'h010] = 32'h2222_0010;
    mem[32'h014] = 32'h2222_0014;
    mem[32'h100] = 32'hCAFE_0100;
    mem[32'h104] = 32'hCAFE_0104;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) if (req_fire_pend[p]) void'(req_q[p].pop_front());
      if (mresp_fire_pend) void'(mem_q.pop_front());
      if (!reset) mem_q.delete();
      for (int p = 0; p < 3; p++) begin
        if (req_q[p].size() > 0) set_req(p, 1'b1, req_q[p][0]);
        else                     set_req(p, 1'b0, '0);
      end
      bus.imemresp0_rdy = resp_rdy[0];
      bus.imemresp1_rdy = resp_rdy[1];
      bus.dmemresp_rdy  = resp_rdy[2];
      from_q = 1'b0;
      if (!mem_stall && mem_q.size() > 0) begin
        bus.memresp_val = 1'b1;
        bus.memresp_msg = mem_q[0];
        from_q = 1'b1;
      end else if (inj_spur) begin
        bus.memresp_val = 1'b1;
        bus.memresp_msg = {1'b0, 2'b00, 32'h5A5A_5A5A};
      end else begin
        bus.memresp_val = 1'b0;
        bus.memresp_msg = '0;
      end
      #1;
      req_fire_pend   = reset ? (w_req_val & w_req_rdy) : 3'b000;
      mresp_fire_pend = reset && from_q && bus.memresp_rdy;
      if (reset && bus.memreq_val && bus.memreq_rdy) begin
        m = bus.memreq_msg;
        if (m[REQ_W-1]) begin
          mem[m[65:34]] = m[31:0];
          mem_q.push_back({1'b1, m[33:32], 32'h0});
        end else begin
          mem_q.push_back({1'b0, m[33:32], mem_rd(m[65:34])});
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int g, e;
    logic [RESP_W-1:0] er;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        if (bus.memreq_val && bus.memreq_rdy) begin
          g = -1;
          for (int p = 0; p < 3; p++) if (w_req_val[p] && w_req_rdy[p]) g = p;
          checks++;
          if (exp_gnt.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: port %0d granted, none required", g);
          end else begin
            e = exp_gnt.pop_front();
            if (g != e) begin
              errors++;
              $display("FAIL grant_order: port %0d granted, required %0d", g, e);
            end else if (bus.memreq_msg !== req_q[g][0]) begin
              errors++;
              $display("FAIL memreq_msg: got %0h, required %0h", bus.memreq_msg, req_q[g][0]);
            end
          end
        end
        for (int p = 0; p < 3; p++) begin
          if (w_resp_val[p] && resp_rdy[p]) begin
            checks++;
            if (exp_q[p].size() == 0) begin
              errors++;
              $display("FAIL resp_unexpected port %0d: got %0h, none required", p, port_resp_msg(p));
            end else begin
              er = exp_q[p].pop_front();
              if (port_resp_msg(p) !== er) begin
                errors++;
                $display("FAIL resp_data port %0d: got %0h, required %0h", p, port_resp_msg(p), er);
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic issue(input int p, input logic t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ed);
    req_q[p].push_back({t, a, 2'b00, d});
    exp_q[p].push_back({t, 2'b00, ed});
    exp_gnt.push_back(p);
  endtask

  function automatic bit idle();
    return req_q[0].size() == 0 && req_q[1].size() == 0 && req_q[2].size() == 0 &&
           exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
           exp_gnt.size() == 0 && mem_q.size() == 0 && bus.outstanding == 0;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (k < budget && !idle()) begin
      tick(1);
      k++;
    end
    if (!idle()) begin
      errors++;
      $display("FAIL timeout %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  initial begin
    // Reset held for two cycles, then released with no traffic.
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rst_req_rdy", REQ_W'(w_req_rdy), 0);
    chk("rst_resp_val", REQ_W'(w_resp_val), 0);
    chk("rst_memreq_val", REQ_W'(bus.memreq_val), 0);
    chk("rst_memresp_rdy", REQ_W'(bus.memresp_rdy), 1);
    chk("rst_outstanding", REQ_W'(bus.outstanding), 0);
    chk("rst_err", REQ_W'(bus.err_spurious), 0);

    // All ports busy: grants 0,1,2,0,1,2.
    issue(0, 1'b0, 32'h000, 32'h0, 32'h1111_0000);
    issue(1, 1'b0, 32'h010, 32'h0, 32'h2222_0010);
    issue(2, 1'b0, 32'h100, 32'h0, 32'hCAFE_0100);
    issue(0, 1'b0, 32'h004, 32'h0, 32'h1111_0004);
    issue(1, 1'b0, 32'h014, 32'h0, 32'h2222_0014);
    issue(2, 1'b0, 32'h104, 32'h0, 32'hCAFE_0104);
    wait_idle("rr_all", 100);

    // dmem-only writes then read-back; pointer should end at 0.
    issue(2, 1'b1, 32'h200, 32'hA0A0_0200, 32'h0);
    issue(2, 1'b1, 32'h204, 32'hA0A0_0204, 32'h0);
    issue(2, 1'b1, 32'h208, 32'hA0A0_0208, 32'h0);
    issue(2, 1'b1, 32'h20C, 32'hA0A0_020C, 32'h0);
    issue(2, 1'b0, 32'h204, 32'h0, 32'hA0A0_0204);
    wait_idle("dmem_wr", 100);
    issue(1, 1'b0, 32'h300, 32'h0, 32'hD00D_0300);
    issue(2, 1'b0, 32'h208, 32'h0, 32'hA0A0_0208);
    wait_idle("ptr_after_dmem", 100);

    // Stalled memory: four accepted, then back-pressure until the first pop.
    mem_stall = 1'b1;
    for (int i = 0; i < 6; i++)
      issue(0, 1'b0, 32'h400 + 32'(4 * i), 32'h0, 32'hD00D_0400 + 32'(4 * i));
    tick(10);
    chk("full_outstanding", REQ_W'(bus.outstanding), 4);
    chk("full_val0", REQ_W'(bus.imemreq0_val), 1);
    chk("full_rdy0", REQ_W'(bus.imemreq0_rdy), 0);
    chk("full_memreq_val", REQ_W'(bus.memreq_val), 0);
    mem_stall = 1'b0;
    tick(1);
    chk("drain_memresp_val", REQ_W'(bus.memresp_val), 1);
    chk("drain_rdy0_still_low", REQ_W'(bus.imemreq0_rdy), 0);
    tick(1);
    chk("drain_rdy0_back", REQ_W'(bus.imemreq0_rdy), 1);
    chk("drain_outstanding", REQ_W'(bus.outstanding), 3);
    wait_idle("stall", 100);

    // Head tag 1 with imemresp1_rdy low holds the FIFO.
    mem_stall = 1'b1;
    resp_rdy = 3'b101;
    issue(1, 1'b0, 32'h010, 32'h0, 32'h2222_0010);
    issue(2, 1'b0, 32'h100, 32'h0, 32'hCAFE_0100);
    tick(4);
    chk("hold_outstanding", REQ_W'(bus.outstanding), 2);
    mem_stall = 1'b0;
    tick(1);
    chk("hold_resp_val", REQ_W'(w_resp_val), 3'b010);
    chk("hold_memresp_rdy", REQ_W'(bus.memresp_rdy), 0);
    tick(3);
    chk("hold_outstanding2", REQ_W'(bus.outstanding), 2);
    chk("hold_memresp_rdy2", REQ_W'(bus.memresp_rdy), 0);
    resp_rdy = 3'b111;
    tick(1);
    chk("release_memresp_rdy", REQ_W'(bus.memresp_rdy), 1);
    chk("release_resp1_val", REQ_W'(w_resp_val), 3'b010);
    tick(1);
    chk("next_resp2_val", REQ_W'(w_resp_val), 3'b100);
    wait_idle("hold", 100);

    // Spurious response with an empty FIFO.
    inj_spur = 1'b1;
    tick(1);
    chk("spur_memresp_val", REQ_W'(bus.memresp_val), 1);
    chk("spur_resp_val", REQ_W'(w_resp_val), 0);
    chk("spur_memresp_rdy", REQ_W'(bus.memresp_rdy), 1);
    chk("spur_err_before", REQ_W'(bus.err_spurious), 0);
    inj_spur = 1'b0;
    tick(1);
    chk("spur_err_set", REQ_W'(bus.err_spurious), 1);
    issue(0, 1'b0, 32'h000, 32'h0, 32'h1111_0000);
    wait_idle("spur_traffic", 100);
    chk("spur_err_sticky", REQ_W'(bus.err_spurious), 1);

    // Reset mid-flight discards tags and clears the flag.
    mem_stall = 1'b1;
    issue(0, 1'b0, 32'h004, 32'h0, 32'h1111_0004);
    tick(3);
    chk("inflight_outstanding", REQ_W'(bus.outstanding), 1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    mem_stall = 1'b0;
    exp_q[0].delete();
    exp_gnt.delete();
    tick(1);
    chk("rst2_outstanding", REQ_W'(bus.outstanding), 0);
    chk("rst2_err", REQ_W'(bus.err_spurious), 0);
    chk("rst2_memresp_rdy", REQ_W'(bus.memresp_rdy), 1);
    chk("rst2_resp_val", REQ_W'(w_resp_val), 0);
    tick(2);
    chk("rst2_err_stays", REQ_W'(bus.err_spurious), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
